row_deserializer: RTL and testbench
===================================

# row_deserializer

Double-buffered stream-to-row converter for the CNN input path: packs 32-bit bus words, each carrying DATA_PER_WORD values, into an N-value row and presents it with row-end tagging. It sits between the host AXI-style word stream and the first CNN layer. It sustains one word per cycle because it fills one row buffer while the other is held for the consumer. It carries an explicit last flag.

## Interface
Parameters:
- N, 28, values per row (≥2)
- DATA_BITS, 8, bits per value
- DATA_PER_WORD, 4, values per input word; DATA_PER_WORD*DATA_BITS ≤ WORD_SIZE
- WORD_SIZE, 32, input word width

Ports:
- clock  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- in_data  in  WORD_SIZE  value k at bits [k*DATA_BITS +: DATA_BITS], k=0 lowest
- in_valid  in  1  word present
- in_last  in  1  word ends the frame
- upstream_stall  out  1  word not accepted this cycle
- out_data  out  DATA_BITS×[N]  row; index 0 = first value received
- out_valid  out  1  row present
- out_last  out  1  row is the frame's final row; qualified by out_valid
- downstream_stall  in  1  consumer not accepting row
- row_count  out  16  rows emitted since reset, wraps at 2^16

## Operation
- Two row buffers B0/B1, each with a full flag and last tag; wr_sel selects the fill buffer, rd_sel the presented buffer; fill index idx counts values, 0..N-1.
- Word accepted iff in_valid && !upstream_stall. On accept, values 0..DATA_PER_WORD-1 are written to B[wr_sel][idx+k] for idx+k < N; values at positions ≥ N are discarded. idx += DATA_PER_WORD.
- Row completes on an accepted word with idx+DATA_PER_WORD ≥ N. On completion: full[wr_sel]←1, last[wr_sel]←in_last, wr_sel flips, idx←0.
- in_last on a non-completing word: see Configuration.
- Drain: out_valid && !downstream_stall → full[rd_sel]←0, rd_sel flips, row_count++.
- Complete and drain in the same cycle both take effect; no bubble.
- upstream_stall = full[wr_sel]. It is a pure register decode with no combinational path from downstream_stall or in_valid.
- out_valid = full[rd_sel]. out_data and out_last come from B[rd_sel] and are stable while out_valid && downstream_stall.

## Timing
- Reset: idx=0, wr_sel=rd_sel=0, full=00, last tags 0, buffers cleared. out_valid=0, out_last=0, out_data all 0, upstream_stall=0, row_count=0.
- Reset mid-row or with rows pending discards all partial and buffered data. No row is emitted for data preceding reset.
- Latency: out_valid rises the cycle after the row-completing word is accepted.
- Throughput: ceil(N/DATA_PER_WORD) cycles per row, back-to-back, with downstream_stall=0.
- Backpressure: with both buffers full, upstream_stall=1 until one drain. The cycle after that drain, upstream_stall=0.
- Empty case: out_valid=0. downstream_stall is ignored and row_count is unchanged.

## Configuration
- ROW_PAD_EN defined: in_last on an accepted non-completing word forces completion. Unwritten positions idx+DATA_PER_WORD..N-1 are zero-filled. last←1 and idx←0. The short row emits with out_last=1, one cycle after acceptance.
- ROW_PAD_EN undefined: in_last on a non-completing word is ignored. Only the row-completing word's in_last sets the row's last tag, and short rows never occur.

## Test plan
- N=28, DATA_PER_WORD=4, words 0x03020100..0x1B1A1918 back-to-back, in_last on word 7, downstream_stall=0 → out_valid is high for 1 cycle, the cycle after word 7. out_data[i]=i and out_last=1. row_count=1. upstream_stall is never 1.
- N=10, DATA_PER_WORD=4, three words 0x03020100, 0x07060504, 0x0B0A0908 → out_data[8]=0x08 and out_data[9]=0x09. Bytes 0x0A/0x0B are dropped. The next row starts at index 0.
- downstream_stall=1 throughout while streaming 3 rows → rows 1 and 2 fill. upstream_stall=1 from the cycle after row 2 completes. Row 1's data is held stable. Releasing the stall for 1 cycle drains row 1 and clears upstream_stall on the next cycle.
- Completion of row 2 in the same cycle as the drain of row 1 → no lost or duplicated row. row_count increments by 1 and out_valid stays high with row 2.
- Assert reset after 3 words of a 7-word row → all outputs hold their reset values. A fresh 7-word row then produces exactly one row containing only post-reset data.
- ROW_PAD_EN, N=28, DATA_PER_WORD=4, in_last on word 2 (values 0..11) → a row emits the cycle after word 2 with out_data[0..11]=0..11, out_data[12..27]=0 and out_last=1. Without the macro, the same stimulus emits no row.

Source files
------------

// File: rtl/row_deserializer.sv
// Double-buffered word-stream to row converter: one buffer fills while the other is presented.
// Optional macro ROW_PAD_EN: in_last on a short row zero-pads it and forces completion.
module row_deserializer #(
  parameter int N             = 28,
  parameter int DATA_BITS     = 8,
  parameter int DATA_PER_WORD = 4,
  parameter int WORD_SIZE     = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [WORD_SIZE-1:0]            in_data,
  input  logic                            in_valid,
  input  logic                            in_last,
  output logic                            upstream_stall,
  output logic [N-1:0][DATA_BITS-1:0]     out_data,
  output logic                            out_valid,
  output logic                            out_last,
  input  logic                            downstream_stall,
  output logic [15:0]                     row_count
);

  localparam int IDX_W = $clog2(N + DATA_PER_WORD);
  localparam logic [IDX_W-1:0] STEP  = IDX_W'(DATA_PER_WORD);
  localparam logic [IDX_W-1:0] LIMIT = IDX_W'(N);

  logic [1:0][N-1:0][DATA_BITS-1:0] buf_q, buf_d;
  logic [1:0]       full_q, full_d;
  logic [1:0]       last_q, last_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      row_count_q, row_count_d;

  logic             accept_s;
  logic             complete_s;
  logic             pad_s;
  logic             drain_s;
  logic [IDX_W-1:0] idx_next_s;

  // Next-state: word packing, row completion and row drain
  always_comb begin
    buf_d       = buf_q;
    full_d      = full_q;
    last_d      = last_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    idx_d       = idx_q;
    row_count_d = row_count_q;

    accept_s   = in_valid && !full_q[wr_sel_q];
    idx_next_s = idx_q + STEP;
    complete_s = accept_s && (idx_next_s >= LIMIT);
`ifdef ROW_PAD_EN
    pad_s      = accept_s && in_last && !complete_s;
`else
    pad_s      = 1'b0;
`endif
    drain_s    = full_q[rd_sel_q] && !downstream_stall;

    if (accept_s) begin
      // Values landing at positions >= N never match a j and are dropped
      for (int j = 0; j < N; j++) begin
        for (int k = 0; k < DATA_PER_WORD; k++) begin
          if (int'(idx_q) + k == j) begin
            buf_d[wr_sel_q][j] = in_data[k*DATA_BITS +: DATA_BITS];
          end
        end
        if (pad_s && (j >= int'(idx_next_s))) begin
          buf_d[wr_sel_q][j] = {DATA_BITS{1'b0}};
        end
      end
      if (complete_s || pad_s) begin
        full_d[wr_sel_q] = 1'b1;
        last_d[wr_sel_q] = in_last;
        wr_sel_d         = ~wr_sel_q;
        idx_d            = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_next_s;
      end
    end else begin
      idx_d = idx_q;
    end

    // Completion needs full[wr_sel]=0 and drain needs full[rd_sel]=1, so they never collide
    if (drain_s) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
      row_count_d      = row_count_q + 16'd1;
    end else begin
      row_count_d = row_count_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_q       <= '0;
      full_q      <= 2'b00;
      last_q      <= 2'b00;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      idx_q       <= {IDX_W{1'b0}};
      row_count_q <= 16'd0;
    end else begin
      buf_q       <= buf_d;
      full_q      <= full_d;
      last_q      <= last_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      idx_q       <= idx_d;
      row_count_q <= row_count_d;
    end
  end

  assign upstream_stall = full_q[wr_sel_q];
  assign out_valid      = full_q[rd_sel_q];
  assign out_data       = buf_q[rd_sel_q];
  assign out_last       = full_q[rd_sel_q] & last_q[rd_sel_q];
  assign row_count      = row_count_q;

endmodule

// File: tb/tb_row_deserializer.sv
// Directed self-checking bench: N=28 instance for main scenarios, N=10 instance for tail-drop.
module tb_row_deserializer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0]          a_data;
  logic                 a_valid, a_last, a_ds, a_us, a_ov, a_ol;
  logic [27:0][7:0]     a_od;
  logic [15:0]          a_rc;

  logic [31:0]          b_data;
  logic                 b_valid, b_last, b_ds, b_us, b_ov, b_ol;
  logic [9:0][7:0]      b_od;
  logic [15:0]          b_rc;

  int n_cmp = 0;
  int n_bad = 0;

  row_deserializer #(.N(28), .DATA_BITS(8), .DATA_PER_WORD(4), .WORD_SIZE(32)) dut28 (
    .clock(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_last(a_last),
    .upstream_stall(a_us), .out_data(a_od), .out_valid(a_ov), .out_last(a_ol),
    .downstream_stall(a_ds), .row_count(a_rc));

  row_deserializer #(.N(10), .DATA_BITS(8), .DATA_PER_WORD(4), .WORD_SIZE(32)) dut10 (
    .clock(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_last(b_last),
    .upstream_stall(b_us), .out_data(b_od), .out_valid(b_ov), .out_last(b_ol),
    .downstream_stall(b_ds), .row_count(b_rc));

  function automatic logic [31:0] mkw(input int base);
    return {8'(base + 3), 8'(base + 2), 8'(base + 1), 8'(base)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; a_valid = 1'b0; a_last = 1'b0; b_valid = 1'b0; b_last = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic send_a(input int base, input logic last);
    a_data = mkw(base); a_valid = 1'b1; a_last = last;
    tick();
  endtask

  task automatic test_reset();
    a_ds = 1'b0; b_ds = 1'b0; a_data = 32'd0; b_data = 32'd0;
    do_reset();
    n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", a_ov); end
    n_cmp++; if (a_ol !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", a_ol); end
    n_cmp++; if (a_od !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", a_od); end
    n_cmp++; if (a_us !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", a_us); end
    n_cmp++; if (a_rc !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", a_rc); end
    n_cmp++; if (b_ov !== 1'b0) begin n_bad++; $display("FAIL reset_valid10: got %b want 0", b_ov); end
  endtask

  task automatic test_full_row();
    do_reset();
    a_ds = 1'b0;
    for (int w = 0; w < 7; w++) begin
      send_a(4 * w, w == 6);
      n_cmp++; if (a_us !== 1'b0) begin n_bad++; $display("FAIL full_stall w%0d: got %b want 0", w, a_us); end
      if (w < 6) begin
        n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL full_early w%0d: got %b want 0", w, a_ov); end
      end
    end
    n_cmp++; if (a_ov !== 1'b1) begin n_bad++; $display("FAIL full_valid: got %b want 1", a_ov); end
    n_cmp++; if (a_ol !== 1'b1) begin n_bad++; $display("FAIL full_last: got %b want 1", a_ol); end
    for (int i = 0; i < 28; i++) begin
      n_cmp++; if (a_od[i] !== 8'(i)) begin n_bad++; $display("FAIL full_data[%0d]: got %h want %h", i, a_od[i], 8'(i)); end
    end
    a_valid = 1'b0; a_last = 1'b0;
    tick();
    n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL full_one_cycle: got %b want 0", a_ov); end
    n_cmp++; if (a_rc !== 16'd1) begin n_bad++; $display("FAIL full_count: got %0d want 1", a_rc); end
  endtask

  task automatic test_drop();
    do_reset();
    b_ds = 1'b0;
    for (int w = 0; w < 3; w++) begin
      b_data = mkw(4 * w); b_valid = 1'b1; b_last = 1'b0;
      tick();
    end
    n_cmp++; if (b_ov !== 1'b1) begin n_bad++; $display("FAIL drop_valid: got %b want 1", b_ov); end
    n_cmp++; if (b_od[8] !== 8'h08) begin n_bad++; $display("FAIL drop_d8: got %h want 08", b_od[8]); end
    n_cmp++; if (b_od[9] !== 8'h09) begin n_bad++; $display("FAIL drop_d9: got %h want 09", b_od[9]); end
    n_cmp++; if (b_od[0] !== 8'h00) begin n_bad++; $display("FAIL drop_d0: got %h want 00", b_od[0]); end
    for (int w = 0; w < 3; w++) begin
      b_data = mkw(16 + 4 * w);
      tick();
    end
    b_valid = 1'b0;
    n_cmp++; if (b_ov !== 1'b1) begin n_bad++; $display("FAIL drop_valid2: got %b want 1", b_ov); end
    n_cmp++; if (b_od[0] !== 8'h10) begin n_bad++; $display("FAIL drop_next_d0: got %h want 10", b_od[0]); end
    n_cmp++; if (b_od[9] !== 8'h19) begin n_bad++; $display("FAIL drop_next_d9: got %h want 19", b_od[9]); end
    n_cmp++; if (b_rc !== 16'd1) begin n_bad++; $display("FAIL drop_count1: got %0d want 1", b_rc); end
    tick();
    n_cmp++; if (b_rc !== 16'd2) begin n_bad++; $display("FAIL drop_count2: got %0d want 2", b_rc); end
  endtask

  task automatic test_backpressure();
    do_reset();
    a_ds = 1'b1;
    for (int w = 0; w < 7; w++) send_a(4 * w, 1'b0);
    n_cmp++; if (a_ov !== 1'b1) begin n_bad++; $display("FAIL bp_row1_valid: got %b want 1", a_ov); end
    n_cmp++; if (a_us !== 1'b0) begin n_bad++; $display("FAIL bp_one_full_stall: got %b want 0", a_us); end
    for (int w = 0; w < 7; w++) send_a(32 + 4 * w, 1'b0);
    n_cmp++; if (a_us !== 1'b1) begin n_bad++; $display("FAIL bp_both_full_stall: got %b want 1", a_us); end
    n_cmp++; if (a_od[0] !== 8'h00) begin n_bad++; $display("FAIL bp_row1_d0: got %h want 00", a_od[0]); end
    a_data = mkw(64); a_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (a_us !== 1'b1) begin n_bad++; $display("FAIL bp_hold_stall c%0d: got %b want 1", c, a_us); end
      n_cmp++; if (a_od[5] !== 8'h05) begin n_bad++; $display("FAIL bp_hold_data c%0d: got %h want 05", c, a_od[5]); end
      n_cmp++; if (a_rc !== 16'd0) begin n_bad++; $display("FAIL bp_hold_count c%0d: got %0d want 0", c, a_rc); end
    end
    a_ds = 1'b0;
    tick();
    a_ds = 1'b1;
    n_cmp++; if (a_us !== 1'b0) begin n_bad++; $display("FAIL bp_release_stall: got %b want 0", a_us); end
    n_cmp++; if (a_ov !== 1'b1) begin n_bad++; $display("FAIL bp_row2_valid: got %b want 1", a_ov); end
    n_cmp++; if (a_od[0] !== 8'h20) begin n_bad++; $display("FAIL bp_row2_d0: got %h want 20", a_od[0]); end
    n_cmp++; if (a_rc !== 16'd1) begin n_bad++; $display("FAIL bp_count: got %0d want 1", a_rc); end
    tick();
    a_valid = 1'b0;
    n_cmp++; if (a_us !== 1'b0) begin n_bad++; $display("FAIL bp_row3_accept: got %b want 0", a_us); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    a_ds = 1'b1;
    for (int w = 0; w < 7; w++) send_a(4 * w, 1'b0);
    for (int w = 0; w < 6; w++) send_a(100 + 4 * w, 1'b0);
    a_ds = 1'b0;
    send_a(124, 1'b0);
    a_valid = 1'b0;
    n_cmp++; if (a_ov !== 1'b1) begin n_bad++; $display("FAIL same_valid: got %b want 1", a_ov); end
    n_cmp++; if (a_od[0] !== 8'd100) begin n_bad++; $display("FAIL same_d0: got %0d want 100", a_od[0]); end
    n_cmp++; if (a_od[27] !== 8'd127) begin n_bad++; $display("FAIL same_d27: got %0d want 127", a_od[27]); end
    n_cmp++; if (a_rc !== 16'd1) begin n_bad++; $display("FAIL same_count1: got %0d want 1", a_rc); end
    n_cmp++; if (a_us !== 1'b0) begin n_bad++; $display("FAIL same_stall: got %b want 0", a_us); end
    tick();
    n_cmp++; if (a_rc !== 16'd2) begin n_bad++; $display("FAIL same_count2: got %0d want 2", a_rc); end
    n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL same_empty: got %b want 0", a_ov); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_ds = 1'b0;
    for (int w = 0; w < 3; w++) send_a(200 + 4 * w, 1'b0);
    a_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", a_ov); end
    n_cmp++; if (a_us !== 1'b0) begin n_bad++; $display("FAIL mid_stall: got %b want 0", a_us); end
    n_cmp++; if (a_rc !== 16'd0) begin n_bad++; $display("FAIL mid_count: got %0d want 0", a_rc); end
    n_cmp++; if (a_od !== '0) begin n_bad++; $display("FAIL mid_data: got %h want 0", a_od); end
    for (int w = 0; w < 7; w++) begin
      send_a(4 * w, 1'b0);
      if (w < 6) begin
        n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL mid_early w%0d: got %b want 0", w, a_ov); end
      end
    end
    a_valid = 1'b0;
    n_cmp++; if (a_ov !== 1'b1) begin n_bad++; $display("FAIL mid_row_valid: got %b want 1", a_ov); end
    n_cmp++; if (a_ol !== 1'b0) begin n_bad++; $display("FAIL mid_row_last: got %b want 0", a_ol); end
    for (int i = 0; i < 28; i++) begin
      n_cmp++; if (a_od[i] !== 8'(i)) begin n_bad++; $display("FAIL mid_data[%0d]: got %h want %h", i, a_od[i], 8'(i)); end
    end
    tick();
    n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL mid_single: got %b want 0", a_ov); end
    n_cmp++; if (a_rc !== 16'd1) begin n_bad++; $display("FAIL mid_count1: got %0d want 1", a_rc); end
  endtask

  task automatic test_pad();
    do_reset();
    a_ds = 1'b0;
    // Dirty both buffers so any padding must actively clear stale values
    for (int w = 0; w < 14; w++) send_a(224 + 4 * (w % 7), 1'b0);
    a_valid = 1'b0;
    tick();
    for (int w = 0; w < 3; w++) send_a(4 * w, w == 2);
    a_valid = 1'b0; a_last = 1'b0;
`ifdef ROW_PAD_EN
    n_cmp++; if (a_ov !== 1'b1) begin n_bad++; $display("FAIL pad_valid: got %b want 1", a_ov); end
    n_cmp++; if (a_ol !== 1'b1) begin n_bad++; $display("FAIL pad_last: got %b want 1", a_ol); end
    for (int i = 0; i < 28; i++) begin
      n_cmp++;
      if (a_od[i] !== ((i < 12) ? 8'(i) : 8'd0)) begin
        n_bad++; $display("FAIL pad_data[%0d]: got %h want %h", i, a_od[i], (i < 12) ? 8'(i) : 8'd0);
      end
    end
    tick();
    n_cmp++; if (a_rc !== 16'd3) begin n_bad++; $display("FAIL pad_count: got %0d want 3", a_rc); end
`else
    n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL nopad_valid: got %b want 0", a_ov); end
    n_cmp++; if (a_us !== 1'b0) begin n_bad++; $display("FAIL nopad_stall: got %b want 0", a_us); end
    tick();
    n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL nopad_valid2: got %b want 0", a_ov); end
    n_cmp++; if (a_rc !== 16'd2) begin n_bad++; $display("FAIL nopad_count: got %0d want 2", a_rc); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_row();
    test_drop();
    test_backpressure();
    test_same_cycle();
    test_reset_mid();
    test_pad();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
